// File: rtl/pipe_sched.sv
// pipe_sched: hazard/scheduling control for a 4-stage pipeline with a
// long-latency multiplier.
//
//   pipe_sched_fwd : per-operand forwarding-source selector.
//   pipe_sched     : top. Forwarding for rs1/rs2, register write enable,
//                    branch flush, and the multiplier FSM that issues
//                    mult_start and stalls decode while a result is pending.
//
// Ports (pipe_sched):
//   clk, reset            clock; asynchronous active-low reset
//   d_valid/d_codop/d_rs1/d_rs2   decode-stage instruction
//   e_valid/e_codop/e_rd  execute-stage instruction
//   m_valid/m_codop/m_rd  memory-stage instruction
//   br_taken              execute resolved a taken jump/beq
//   stall, flush          pipeline control
//   fwd_a, fwd_b          operand source: 00 regbank, 01 execute, 10 memory
//   mult_start, mult_busy multiplier control/status
//   wen                   register-bank write enable (memory stage)
//   stall_cnt             saturating stall-cycle counter

// Forwarding selector for one source operand. Execute is the youngest
// producer, so it wins over memory.
module pipe_sched_fwd (
  input  logic [3:0] rs,
  input  logic       e_wr,
  input  logic [3:0] e_rd,
  input  logic       m_wr,
  input  logic [3:0] m_rd,
  output logic [1:0] fwd
);
  always_comb begin
    fwd = 2'b00;
    if (e_wr && (e_rd == rs))      fwd = 2'b01;
    else if (m_wr && (m_rd == rs)) fwd = 2'b10;
  end
endmodule

module pipe_sched #(
  parameter int MULT_LAT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [3:0] d_codop,
  input  logic [3:0] d_rs1,
  input  logic [3:0] d_rs2,
  input  logic       e_valid,
  input  logic [3:0] e_codop,
  input  logic [3:0] e_rd,
  input  logic       m_valid,
  input  logic [3:0] m_codop,
  input  logic [3:0] m_rd,
  input  logic       br_taken,
  output logic       stall,
  output logic       flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mult_start,
  output logic       mult_busy,
  output logic       wen,
  output logic [7:0] stall_cnt
);

  localparam int         NUM_OPS = 2;
  localparam logic [7:0] LAT_M1  = 8'(MULT_LAT - 1);

  localparam logic [3:0] OP_JMP  = 4'b1011;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_MFLO = 4'b1101;
  localparam logic [3:0] OP_MFHI = 4'b1110;
  localparam logic [3:0] OP_MULT = 4'b1111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic is_writer(input logic [3:0] op);
    return !((op == OP_JMP) || (op == OP_BEQ) || (op == OP_MULT));
  endfunction

  // ---------------------------------------------------------------
  // Forwarding and write enable (pure combinational)
  // ---------------------------------------------------------------
  logic                     e_wr, m_wr;
  logic [NUM_OPS-1:0][3:0]  rs_vec;
  logic [NUM_OPS-1:0][1:0]  fwd_vec;

  assign e_wr   = e_valid && is_writer(e_codop);
  assign m_wr   = m_valid && is_writer(m_codop);
  assign wen    = m_wr;
  assign rs_vec = {d_rs2, d_rs1};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    pipe_sched_fwd u_fwd (
      .rs   (rs_vec[i]),
      .e_wr (e_wr),
      .e_rd (e_rd),
      .m_wr (m_wr),
      .m_rd (m_rd),
      .fwd  (fwd_vec[i])
    );
  end

  assign fwd_a = fwd_vec[0];
  assign fwd_b = fwd_vec[1];

  // A taken branch kills decode in the same cycle.
  assign flush = br_taken;

  // ---------------------------------------------------------------
  // Multiplier FSM
  // ---------------------------------------------------------------
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       d_is_mult, d_uses_mult;

  assign d_is_mult   = d_valid && (d_codop == OP_MULT);
  // A new mult also waits, otherwise it would clobber the running one.
  assign d_uses_mult = d_valid && ((d_codop == OP_MFLO) ||
                                   (d_codop == OP_MFHI) ||
                                   (d_codop == OP_MULT));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    mult_start = 1'b0;
    mult_busy  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // reset term keeps the start pulse quiet while reset is held.
        if (d_is_mult && !flush && reset) begin
          mult_start = 1'b1;
          cnt_d      = LAT_M1;
          state_d    = RUN;
        end
      end
      RUN: begin
        mult_busy = 1'b1;
        // Flush wins: the decode slot is being discarded anyway.
        stall     = d_uses_mult && !flush;
        if (cnt_q == 8'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 8'hFF)) stall_cnt_d = stall_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      stall_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_sched.sv
// Testbench for pipe_sched (MULT_LAT=4). Reference model tracks the
// multiplier as "issued at cycle S, busy for cycles S+1..S+LAT" and the
// rest of the outputs straight from the opcode rules.
module tb_pipe_sched;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [3:0] d_codop, d_rs1, d_rs2;
  logic       e_valid;
  logic [3:0] e_codop, e_rd;
  logic       m_valid;
  logic [3:0] m_codop, m_rd;
  logic       br_taken;
  logic       stall, flush, mult_start, mult_busy, wen;
  logic [1:0] fwd_a, fwd_b;
  logic [7:0] stall_cnt;

  pipe_sched #(.MULT_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid), .d_codop(d_codop), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .e_valid(e_valid), .e_codop(e_codop), .e_rd(e_rd),
    .m_valid(m_valid), .m_codop(m_codop), .m_rd(m_rd),
    .br_taken(br_taken),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mult_start(mult_start), .mult_busy(mult_busy), .wen(wen),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  int  cyc = 0;
  int  start_cyc = 0;
  bit  issued = 0;
  int  scnt = 0;
  bit  x_busy, x_stall, x_start;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit writer(input logic [3:0] op);
    return op inside {[4'd0:4'd10], 4'd13, 4'd14};
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [3:0] rs);
    if (e_valid && writer(e_codop) && e_rd == rs) return 2'b01;
    if (m_valid && writer(m_codop) && m_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    issued = 0;
    scnt   = 0;
  endtask

  // Compare all outputs against the model mid-cycle.
  task automatic settle();
    @(negedge clk);
    x_busy  = issued && (cyc - start_cyc >= 1) && (cyc - start_cyc <= LAT);
    x_stall = x_busy && d_valid && (d_codop inside {4'd13, 4'd14, 4'd15}) && !br_taken;
    x_start = !x_busy && d_valid && d_codop == 4'd15 && !br_taken && reset;
    chk("stall",      stall,      x_stall);
    chk("mult_busy",  mult_busy,  x_busy);
    chk("mult_start", mult_start, x_start);
    chk("flush",      flush,      br_taken);
    chk("wen",        wen,        m_valid && writer(m_codop));
    chk("fwd_a",      fwd_a,      ref_fwd(d_rs1));
    chk("fwd_b",      fwd_b,      ref_fwd(d_rs2));
    chk("stall_cnt",  stall_cnt,  scnt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else begin
      if (x_start) begin issued = 1; start_cyc = cyc; end
      if (x_stall && scnt < 255) scnt++;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    settle();
    tick();
    #1 reset = 1'b1;
  endtask

  task automatic quiet();
    d_valid = 0; d_codop = 0; d_rs1 = 0; d_rs2 = 0;
    e_valid = 0; e_codop = 0; e_rd = 0;
    m_valid = 0; m_codop = 0; m_rd = 0;
    br_taken = 0;
  endtask

  task automatic rand_inputs();
    d_valid  = ($urandom_range(0, 7) != 0);
    d_codop  = ($urandom_range(0, 2) == 0) ? 4'(13 + $urandom_range(0, 2))
                                           : 4'($urandom_range(0, 15));
    d_rs1    = 4'($urandom_range(0, 3));
    d_rs2    = 4'($urandom_range(0, 3));
    e_valid  = 1'($urandom_range(0, 1));
    e_codop  = 4'($urandom_range(0, 15));
    e_rd     = 4'($urandom_range(0, 3));
    m_valid  = 1'($urandom_range(0, 1));
    m_codop  = 4'($urandom_range(0, 15));
    m_rd     = 4'($urandom_range(0, 3));
    br_taken = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    quiet();
    // reset state
    reset = 1'b0;
    model_reset();
    d_valid = 1; d_codop = 4'b1111;
    settle();
    chk("rst_start", mult_start, 0);
    chk("rst_busy",  mult_busy,  0);
    chk("rst_cnt",   stall_cnt,  0);
    tick();
    #1 reset = 1'b1;
    quiet();

    // forwarding priority
    e_valid = 1; e_codop = 4'b0000; e_rd = 3;
    m_valid = 1; m_codop = 4'b0001; m_rd = 3;
    d_rs1 = 3; d_rs2 = 3;
    settle();
    chk("prio_a", fwd_a, 2'b01);
    chk("prio_b", fwd_b, 2'b01);
    tick();
    e_codop = 4'b1011;
    settle();
    chk("nonwr_a", fwd_a, 2'b10);
    chk("wen_wr",  wen,   1);
    tick();
    m_codop = 4'b1100;
    settle();
    chk("none_a", fwd_a, 2'b00);
    chk("wen_nw", wen,   0);
    tick();
    quiet();

    // IDLE read of mult result never stalls
    d_valid = 1; d_codop = 4'b1101;
    settle();
    chk("idle_rd", stall, 0);
    tick();

    // multiply sequence
    d_codop = 4'b1111;
    settle();
    chk("seq_start", mult_start, 1);
    tick();
    d_codop = 4'b1101;
    for (int i = 0; i < LAT; i++) begin
      settle();
      chk("seq_stall", stall, 1);
      chk("seq_busy",  mult_busy, 1);
      chk("seq_nostart", mult_start, 0);
      tick();
    end
    settle();
    chk("seq_done_stall", stall, 0);
    chk("seq_done_busy",  mult_busy, 0);
    chk("seq_cnt", stall_cnt, 4);
    tick();

    // branch vs stall
    d_codop = 4'b1111;
    settle();
    tick();
    d_codop = 4'b1110; br_taken = 1;
    settle();
    chk("br_flush", flush, 1);
    chk("br_stall", stall, 0);
    tick();
    br_taken = 0;
    settle();
    chk("br_run", mult_busy, 1);
    chk("br_resume", stall, 1);
    tick();
    quiet();
    for (int i = 0; i < LAT; i++) begin settle(); tick(); end

    // flush suppresses start
    do_reset();
    d_valid = 1; d_codop = 4'b1111; br_taken = 1;
    settle();
    chk("fl_start", mult_start, 0);
    tick();
    br_taken = 0; d_codop = 4'b1101;
    settle();
    chk("fl_idle_busy",  mult_busy, 0);
    chk("fl_idle_stall", stall, 0);
    tick();

    // async reset mid-run
    do_reset();
    d_valid = 1; d_codop = 4'b1111;
    settle();
    tick();
    d_codop = 4'b1101;
    settle();
    tick();
    #1 reset = 1'b0;
    model_reset();
    #1;
    chk("ar_busy",  mult_busy,  0);
    chk("ar_cnt",   stall_cnt,  0);
    chk("ar_stall", stall,      0);
    chk("ar_start", mult_start, 0);
    settle();
    tick();
    #1 reset = 1'b1;
    settle();
    chk("ar_rel_stall", stall, 0);
    tick();

    // randomized traffic with an occasional async reset
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      if (i == 200) begin
        #2 reset = 1'b0;
        model_reset();
        #1 reset = 1'b1;
      end
      settle();
      tick();
    end

    // saturation: back-to-back mults held in decode
    quiet();
    do_reset();
    d_valid = 1; d_codop = 4'b1111;
    for (int i = 0; i < 330; i++) begin
      settle();
      tick();
    end
    settle();
    chk("sat_255", stall_cnt, 255);
    tick();
    settle();
    chk("sat_hold", stall_cnt, 255);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
